// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, BURST} state_t;

   localparam int N_REQ_DEF     = 4;
   localparam int DW_DEF        = 4;
   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W_DEF     = 16;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward
// from last+1, wrapping modulo N.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         any,
   output logic [W-1:0] idx
);

   logic         found;
   logic [W-1:0] cand;

   assign any = |req;

   // Scan N candidates starting just after the previous winner.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(last) + k) % N);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among N_REQ
// requesters, with bounded bursts, lossless stall on full and per-requester
// accepted-beat counters. Lives entirely in the FIFO write-clock domain.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      wr_rst,
   input  logic                      arb_en,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DW-1:0]       req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DW-1:0]             fifo_wdata,
   output logic [id_w(N_REQ)-1:0]    grant_id,
   output logic                      busy,
   output logic [N_REQ*CNT_W-1:0]    beat_cnt
);

   localparam int GW = id_w(N_REQ);

   state_t              state;
   state_t              state_next;
   logic [GW-1:0]       last_grant;
   logic [GW-1:0]       pick_idx;
   logic                pick_any;
   logic [7:0]          burst_cnt;
   logic                grant_valid;
   logic                xfer;
   logic                last_beat;
   logic [CNT_W-1:0]    cnt [N_REQ];

   rr_pick #(
      .N (N_REQ),
      .W (GW)
   ) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign grant_valid = req_valid[grant_id];
   assign busy        = (state == BURST);
   assign xfer        = busy && grant_valid && !fifo_full;
   assign last_beat   = (burst_cnt == 8'(MAX_BURST - 1));
   assign fifo_wr_en  = xfer;
   assign fifo_wdata  = req_data[int'(grant_id)*DW +: DW];

   // Only the granted requester sees ready, and only while the FIFO has room.
   always_comb begin
      req_ready = '0;
      if (busy && !fifo_full) req_ready[grant_id] = 1'b1;
   end

   // Next state: grant when allowed, release on the final beat or when the
   // granted requester drops valid. A full FIFO simply holds BURST.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arb_en && pick_any) state_next = BURST;
         BURST: begin
            if (xfer && last_beat)  state_next = IDLE;
            else if (!grant_valid)  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, grant bookkeeping and beat counters; reset aborts any burst.
   always_ff @(posedge clk or negedge wr_rst) begin
      if (!wr_rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(N_REQ - 1);
         burst_cnt  <= '0;
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && arb_en && pick_any) begin
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            burst_cnt  <= '0;
         end
         if (xfer) begin
            burst_cnt     <= burst_cnt + 8'd1;
            cnt[grant_id] <= cnt[grant_id] + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
      assign beat_cnt[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: table-driven steady-state bursts plus
// hand-written sequences for stall, early release, arb_en gating and reset.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        wr_rst = 1'b0;
   logic        arb_en = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [3:0]  fifo_wdata;
   logic [1:0]  grant_id;
   logic        busy;
   logic [63:0] beat_cnt;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter dut (
      .clk        (clk),
      .wr_rst     (wr_rst),
      .arb_en     (arb_en),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_wdata (fifo_wdata),
      .grant_id   (grant_id),
      .busy       (busy),
      .beat_cnt   (beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_first;
      logic [3:0]  valid;
      logic [15:0] data;
      logic        exp_busy;
      logic [1:0]  exp_gid;
      logic        exp_wen;
      logic [3:0]  exp_ready;
      logic [3:0]  exp_wdata;
   } vec_t;

   vec_t tbl [35];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cnt_of(input int i);
      return beat_cnt[i*16 +: 16];
   endfunction

   // Hold reset for two edges, release 1 time unit after a rising edge.
   task automatic do_reset();
      wr_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 wr_rst = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] wr_log [$];
   logic [3:0] d1;

   initial begin
      // Steady-state tables: single requester (10 cycles), then all four (25 cycles).
      for (int c = 0; c < 10; c++) begin
         tbl[c].rst_first = (c == 0);
         tbl[c].valid     = 4'b0001;
         tbl[c].data      = 16'h0005;
         tbl[c].exp_busy  = (c % 5) != 0;
         tbl[c].exp_gid   = 2'd0;
         tbl[c].exp_wen   = (c % 5) != 0;
         tbl[c].exp_ready = ((c % 5) != 0) ? 4'b0001 : 4'b0000;
         tbl[c].exp_wdata = 4'h5;
      end
      for (int c = 0; c < 25; c++) begin
         int b;
         int g;
         b = c / 5;
         g = ((c % 5) != 0) ? (b % 4) : ((b == 0) ? 0 : ((b - 1) % 4));
         tbl[10+c].rst_first = (c == 0);
         tbl[10+c].valid     = 4'b1111;
         tbl[10+c].data      = 16'h4321;
         tbl[10+c].exp_busy  = (c % 5) != 0;
         tbl[10+c].exp_gid   = 2'(g);
         tbl[10+c].exp_wen   = (c % 5) != 0;
         tbl[10+c].exp_ready = ((c % 5) != 0) ? 4'(1 << g) : 4'b0000;
         tbl[10+c].exp_wdata = 4'(g + 1);
      end

      // Reset state, observed while reset is held.
      #2;
      check("rst_busy", 32'(busy), 0);
      check("rst_wen", 32'(fifo_wr_en), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_gid", 32'(grant_id), 0);
      check("rst_cnt", beat_cnt[31:0] | beat_cnt[63:32], 0);

      for (int i = 0; i < 35; i++) begin
         req_valid = tbl[i].valid;
         req_data  = tbl[i].data;
         fifo_full = 1'b0;
         arb_en    = 1'b1;
         if (tbl[i].rst_first) do_reset();
         @(negedge clk);
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
         check($sformatf("tbl%0d_wen", i), 32'(fifo_wr_en), 32'(tbl[i].exp_wen));
         check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
         if (tbl[i].exp_busy)
            check($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].exp_gid));
         if (tbl[i].exp_wen)
            check($sformatf("tbl%0d_wdata", i), 32'(fifo_wdata), 32'(tbl[i].exp_wdata));
         next_cycle();
         if (i == 9) check("t1_cnt0", 32'(cnt_of(0)), 8);
         if (i == 29)
            for (int r = 0; r < 4; r++) check($sformatf("t2_cnt%0d_mid", r), 32'(cnt_of(r)), 4);
      end
      check("t2_cnt0_end", 32'(cnt_of(0)), 8);

      // Stall: requester 1 granted, FIFO full for 3 cycles after beat 2.
      req_valid = 4'b0010;
      d1 = 4'h8;
      req_data = {8'h00, d1, 4'h0};
      fifo_full = 1'b0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         logic ew;
         fifo_full = (c >= 3 && c <= 5);
         ew = (c == 1 || c == 2 || c == 6 || c == 7);
         @(negedge clk);
         check($sformatf("stall%0d_wen", c), 32'(fifo_wr_en), 32'(ew));
         check($sformatf("stall%0d_ready", c), 32'(req_ready), ew ? 32'h2 : 32'h0);
         check($sformatf("stall%0d_busy", c), 32'(busy), (c >= 1 && c <= 7) ? 1 : 0);
         if (c >= 1 && c <= 7) check($sformatf("stall%0d_gid", c), 32'(grant_id), 1);
         if (fifo_wr_en) wr_log.push_back(fifo_wdata);
         next_cycle();
         if (ew) begin
            d1 = d1 + 4'h1;
            req_data = {8'h00, d1, 4'h0};
         end
         if (c == 7) req_valid = 4'b0000;
      end
      check("stall_cnt1", 32'(cnt_of(1)), 4);
      check("stall_nwrites", 32'(wr_log.size()), 4);
      for (int k = 0; k < wr_log.size() && k < 4; k++)
         check($sformatf("stall_data%0d", k), 32'(wr_log[k]), 32'(8 + k));

      // Early release: requester 2 drops valid after one beat, 3 is next.
      req_valid = 4'b1100;
      req_data  = 16'hBA00;
      do_reset();
      @(negedge clk);
      check("drop_c0_busy", 32'(busy), 0);
      next_cycle();
      @(negedge clk);
      check("drop_c1_gid", 32'(grant_id), 2);
      check("drop_c1_wen", 32'(fifo_wr_en), 1);
      check("drop_c1_wdata", 32'(fifo_wdata), 32'hA);
      next_cycle();
      req_valid = 4'b1000;
      @(negedge clk);
      check("drop_c2_busy", 32'(busy), 1);
      check("drop_c2_wen", 32'(fifo_wr_en), 0);
      next_cycle();
      @(negedge clk);
      check("drop_c3_busy", 32'(busy), 0);
      next_cycle();
      @(negedge clk);
      check("drop_c4_busy", 32'(busy), 1);
      check("drop_c4_gid", 32'(grant_id), 3);
      check("drop_cnt2", 32'(cnt_of(2)), 1);

      // arb_en dropped mid-burst of requester 0: burst completes, no new grant.
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      arb_en    = 1'b1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c == 2) arb_en = 1'b0;
         if (c == 8) arb_en = 1'b1;
         @(negedge clk);
         check($sformatf("en%0d_busy", c), 32'(busy), ((c >= 1 && c <= 4) || c == 9) ? 1 : 0);
         check($sformatf("en%0d_wen", c), 32'(fifo_wr_en), ((c >= 1 && c <= 4) || c == 9) ? 1 : 0);
         if (c == 9) check("en_next_gid", 32'(grant_id), 1);
         next_cycle();
      end
      check("en_cnt0", 32'(cnt_of(0)), 4);

      // Asynchronous reset mid-burst of requester 2.
      req_valid = 4'b0100;
      do_reset();
      next_cycle();
      @(negedge clk);
      check("ar_pre_busy", 32'(busy), 1);
      check("ar_pre_gid", 32'(grant_id), 2);
      next_cycle();
      #2 wr_rst = 1'b0;
      #1;
      check("ar_wen", 32'(fifo_wr_en), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_ready", 32'(req_ready), 0);
      check("ar_cnt", beat_cnt[31:0] | beat_cnt[63:32], 0);
      next_cycle();
      req_valid = 4'b1111;
      wr_rst = 1'b1;
      @(negedge clk);
      check("ar_idle_busy", 32'(busy), 0);
      next_cycle();
      @(negedge clk);
      check("ar_first_busy", 32'(busy), 1);
      check("ar_first_gid", 32'(grant_id), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against any unexpected stall of the sequence above.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one asynchronous FIFO write port among N_REQ requesters.
- Runs entirely in the FIFO write-clock domain. Its fifo_wr_en/fifo_wdata drive the FIFO's wr_en/data_in; fifo_full comes from the FIFO's full output.
- Grants bounded bursts (at most MAX_BURST beats per grant), stalls losslessly on full, and keeps per-requester accepted-beat counters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 4, data width; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..255).
- CNT_W, 16, width of each per-requester beat counter.

Ports:
- clk  input  1  write-side clock (same as FIFO wr_clk).
- wr_rst  input  1  reset, asynchronous, active-low.
- arb_en  input  1  1 = new grants allowed.
- req_valid  input  N_REQ  per-requester data valid.
- req_data  input  N_REQ*DW  requester i data at bits [i*DW +: DW].
- req_ready  output  N_REQ  per-requester accept strobe.
- fifo_full  input  1  FIFO full flag (write domain).
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wdata  output  DW  FIFO write data.
- grant_id  output  clog2(N_REQ)  currently granted requester.
- busy  output  1  high while in BURST.
- beat_cnt  output  N_REQ*CNT_W  accepted beats per requester, flattened like req_data.

Behaviour:
- Reset (wr_rst low, asynchronous): state=IDLE, grant_id=0, busy=0, beat counter=0, all beat_cnt=0, last_grant=N_REQ-1 (requester 0 has first priority). Consequently req_ready=0 and fifo_wr_en=0.
- FSM states:
  - IDLE: if arb_en && |req_valid, pick the first valid requester searching from last_grant+1 modulo N_REQ. Register grant_id and last_grant to that index, clear the burst counter, go to BURST. Otherwise stay in IDLE.
  - BURST: busy=1. A transfer happens in a cycle where req_valid[grant_id] && !fifo_full.
- Transfer logic (combinational, zero latency):
  - req_ready[grant_id] = BURST && !fifo_full; all other req_ready bits = 0.
  - fifo_wr_en = BURST && req_valid[grant_id] && !fifo_full.
  - fifo_wdata = req_data slice for grant_id in every cycle; its value is don't-care when fifo_wr_en=0.
- Beat counting:
  - On each transfer: burst counter +1 and beat_cnt[grant_id] +1.
  - beat_cnt wraps modulo 2^CNT_W; it does not saturate.
- BURST exit to IDLE, taken on the next clk edge:
  - transfer that makes the burst counter reach MAX_BURST, or
  - req_valid[grant_id]=0 in that cycle (no transfer happens).
- fifo_full during BURST: hold grant, counter and state; no write; no timeout. The write is never dropped because the arbiter never asserts wr_en while full.
- Arbitration bubble: exactly one IDLE cycle between consecutive bursts, so sustained throughput is MAX_BURST/(MAX_BURST+1).
- arb_en=0:
  - Blocks only IDLE→BURST.
  - A burst in progress completes normally.
  - last_grant is preserved, so rotation resumes where it stopped.
- Requester protocol: data must be held stable while valid && !ready. Dropping valid without a transfer is legal and releases the grant.
- A wr_rst assertion mid-burst aborts the burst immediately; no partial-state recovery.
- Reset synchronization to the rd domain is outside this block.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, BURST};
  - default values for N_REQ, DW, MAX_BURST, CNT_W;
  - the clog2-based width function for grant_id.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, last index.
  - Outputs: any, index.
  - Unit-testable in isolation.

Test Plan:
- After reset, req_valid=4'b0001, req_data[0]=4'h5, fifo_full=0 held → grant_id=0. Repeating pattern of 4 cycles fifo_wr_en=1 with fifo_wdata=5, then 1 cycle idle. beat_cnt[0]=8 after 10 cycles.
- req_valid=4'b1111 held, fifo_full=0 → grants in order 0,1,2,3,0, each 4 beats. Each beat_cnt=4 after the first 20 cycles following the first grant.
- Requester 1 granted, fifo_full=1 after beat 2 for 3 cycles → req_ready=0 and fifo_wr_en=0 for those 3 cycles, grant_id stays 1. Beats 3 and 4 then written, then release. beat_cnt[1]=4 and no value lost.
- Requester 2 granted, req_valid[2] drops after 1 beat while req_valid[3]=1 → IDLE, then grant_id=3. beat_cnt[2]=1.
- All valid, arb_en=0 mid-burst of requester 0 → burst finishes at 4 beats, then busy=0 and no grant. arb_en=1 → next grant_id=1.
- wr_rst low during burst of requester 2 → fifo_wr_en, busy, req_ready and beat_cnt go to 0 without a clock edge. After release with all valid, the first grant is 0.
